// File: rtl/pipe_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mux_n
// Brief    : N-way WIDTH-bit select feeding a 2-entry valid/ready skid stage.
//            Optional sticky out-of-range select flag: define MUX_SEL_ERR_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipe_mux_n #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef MUX_SEL_ERR_EN
  output logic               sel_err,
`endif
  input  logic               flush
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;

  logic [WIDTH-1:0] w_sel_word;
  logic             w_accept;
  logic             w_handoff;
  logic             w_main_free;

  // Unmatched select codes fall through to channel 0, so no index exceeds N-1.
  always_comb begin
    w_sel_word = in_data[WIDTH-1:0];
    for (int k = 1; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_accept    = in_valid & ~skid_valid_q;
  assign w_handoff   = out_valid_q & out_ready;
  assign w_main_free = ~out_valid_q | out_ready;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-main move can happen.
      if (w_handoff) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (w_main_free) begin
        out_data_d  = w_sel_word;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d  = w_sel_word;
        skid_valid_d = 1'b1;
      end
    end else if (w_handoff) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef MUX_SEL_ERR_EN
  logic sel_err_q, sel_err_d;
  logic w_sel_oor;

  assign w_sel_oor = ({1'b0, sel} >= (SEL_W+1)'(N));

  always_comb begin
    sel_err_d = sel_err_q;
    if (flush) begin
      sel_err_d = 1'b0;
    end else if (w_accept && w_sel_oor) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_mux_n
// Brief    : Self-checking bench for pipe_mux_n against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_mux_n;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [SW-1:0]  sel;
  logic           in_valid, in_ready, out_valid, out_ready, flush;
  logic [W-1:0]   out_data;

  logic [3*W-1:0] in_data3;
  logic [1:0]     sel3;
  logic           in_valid3, in_ready3, out_valid3;
  logic [W-1:0]   out_data3;
`ifdef MUX_SEL_ERR_EN
  logic           sel_err, sel_err3;
`endif

  pipe_mux_n #(.WIDTH(W), .N(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_SEL_ERR_EN
    .sel_err(sel_err),
`endif
    .flush(flush)
  );

  pipe_mux_n #(.WIDTH(W), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(1'b1),
`ifdef MUX_SEL_ERR_EN
    .sel_err(sel_err3),
`endif
    .flush(flush)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  logic [W-1:0] q[$];   // words held by the block, oldest first

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input logic [SW-1:0] s);
    if (int'(s) < N) return d[int'(s)*W +: W];
    return d[W-1:0];
  endfunction

  // One clock: predict from inputs, advance the model, compare after the edge.
  task automatic cycle();
    bit           acc, ho, fl;
    logic [W-1:0] w;
    fl  = flush;
    acc = in_valid && (q.size() < 2);
    ho  = (q.size() > 0) && out_ready;
    w   = pick(in_data, sel);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (ho) void'(q.pop_front());
      if (acc) q.push_back(w);
    end
    chk("out_valid", W'(out_valid), W'(q.size() > 0));
    chk("in_ready", W'(in_ready), W'(q.size() < 2));
    if (q.size() > 0) chk("out_data", out_data, q[0]);
  endtask

  initial begin
    logic [W-1:0] a, b, c;
    a = 32'hAAAA_AAAA; b = 32'hBBBB_BBBB; c = 32'hCCCC_CCCC;
    rst_n = 1'b0; in_data = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_data3 = '0; sel3 = '0; in_valid3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", W'(out_valid), 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", W'(in_ready), 1);
`ifdef MUX_SEL_ERR_EN
    chk("reset_sel_err", W'(sel_err), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, one select per cycle
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'h1000_0000 + W'(k);
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      sel = SW'(k); in_valid = 1'b1;
      cycle();
      chk("stream_word", out_data, 32'h1000_0000 + W'(k));
    end
    in_valid = 1'b0;
    cycle();

    // Stall fills the skid
    out_ready = 1'b0; sel = '0;
    in_data[W-1:0] = a; in_valid = 1'b1; cycle();
    in_data[W-1:0] = b; cycle();
    in_valid = 1'b0; cycle();
    chk("stall_in_ready", W'(in_ready), 0);
    chk("stall_hold_A", out_data, a);
    out_ready = 1'b1; cycle();
    chk("release_B", out_data, b);
    chk("release_in_ready", W'(in_ready), 1);
    cycle();
    chk("release_drained", W'(out_valid), 0);

    // Flush with skid full discards everything including the word offered
    out_ready = 1'b0;
    in_data[W-1:0] = a; in_valid = 1'b1; cycle();
    in_data[W-1:0] = b; cycle();
    flush = 1'b1; in_data[W-1:0] = c; cycle();
    chk("flush_out_valid", W'(out_valid), 0);
    chk("flush_in_ready", W'(in_ready), 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset with a word in flight
    out_ready = 1'b0; in_data[W-1:0] = 32'hDDDD_0001; in_valid = 1'b1; cycle();
    in_valid = 1'b0;
    chk("pre_reset_valid", W'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", W'(out_valid), 0);
    chk("async_out_data", out_data, 0);
    chk("async_in_ready", W'(in_ready), 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Out-of-range select on the 3-channel instance
    in_data3 = {32'h2222_2222, 32'h1111_1111, 32'h0000_0F00};
    sel3 = 2'd3; in_valid3 = 1'b1;
    cycle();
    in_valid3 = 1'b0;
    chk("oor_valid", W'(out_valid3), 1);
    chk("oor_data", out_data3, 32'h0000_0F00);
`ifdef MUX_SEL_ERR_EN
    cycle();
    chk("oor_sel_err_set", W'(sel_err3), 1);
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("oor_sel_err_clear", W'(sel_err3), 0);
`endif
    sel3 = 2'd2; in_valid3 = 1'b1; cycle(); in_valid3 = 1'b0;
    chk("ch2_data", out_data3, 32'h2222_2222);

    // Randomised traffic
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom;
      sel       = SW'($urandom);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 63) == 0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
`default_nettype wire
